// File: rtl/disp_pkg.sv
// Shared types and constants for the BCD display driver and its converter.
package disp_pkg;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   typedef enum logic {IDLE, CONV} conv_state_t;

   function automatic int max_bcd(int digits);
      int r;
      r = 1;
      for (int i = 0; i < digits; i++) r = r * 10;
      return r - 1;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// done_o and bcd_o are valid together in the final iteration cycle, so the
// consumer captures the finished digits on the same edge the FSM returns to IDLE.
module bin2bcd_seq
   import disp_pkg::*;
#(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      value_i,
   output conv_state_t           state_o,
   output logic                  done_o,
   output logic [DIGITS*4-1:0]   bcd_o
);

   localparam int BW = DIGITS * 4;
   localparam int CW = $clog2(WIDTH + 1);

   conv_state_t       state_q, state_d;
   logic [WIDTH-1:0]  sh_q, sh_d;
   logic [BW-1:0]     acc_q, acc_d, adj;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              last;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
      end
      last    = (cnt_q == CW'(WIDTH - 1));
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      done_o  = 1'b0;
      // Result of the current iteration, i.e. the finished BCD in the last one.
      bcd_o   = {adj[BW-2:0], sh_q[WIDTH-1]};
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = CONV;
               sh_d    = value_i;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         CONV: begin
            acc_d = {adj[BW-2:0], sh_q[WIDTH-1]};
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               state_d = IDLE;
               done_o  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign state_o = state_q;

endmodule

// File: rtl/bcd_display_driver.sv
// Binary value -> BCD digits, time-multiplexed onto a shared digit bus.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero one.
module bcd_display_driver
   import disp_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int WIDTH       = 14,
   parameter int REFRESH_DIV = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WIDTH-1:0]  value,
   output logic              busy,
   output logic              overflow,
   output logic [3:0]        digit_data,
   output logic [DIGITS-1:0] anodes
);

   localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNW = $clog2(REFRESH_DIV);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(max_bcd(DIGITS));

   conv_state_t              conv_state;
   logic                     conv_done;
   logic [DIGITS*4-1:0]      bcd;
   logic                     accept;

   logic                     ovf_pend_q, ovf_pend_d;
   logic                     overflow_q, overflow_d;
   logic [DIGITS-1:0][3:0]   disp_q, disp_d;
   logic [CNW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [DIGITS-1:0]        anodes_q, anodes_d;
   logic [3:0]               digit_q, digit_d;
`ifdef LEADING_ZERO_BLANK_EN
   logic                     lead;
`endif

   assign busy   = (conv_state == CONV);
   assign accept = load & ~busy;

   bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
      .clk_i   (clk),
      .reset_i (reset),
      .start_i (accept),
      .value_i (value),
      .state_o (conv_state),
      .done_o  (conv_done),
      .bcd_o   (bcd)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_pend_q <= 1'b0;
         overflow_q <= 1'b0;
         disp_q     <= {DIGITS{BLANK_CODE}};
         cnt_q      <= '0;
         idx_q      <= '0;
         anodes_q   <= ~DIGITS'(1);
         digit_q    <= BLANK_CODE;
      end else begin
         ovf_pend_q <= ovf_pend_d;
         overflow_q <= overflow_d;
         disp_q     <= disp_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         anodes_q   <= anodes_d;
         digit_q    <= digit_d;
      end
   end

   // Range is judged on the accepted value; it is published only at completion.
   always_comb begin
      ovf_pend_d = accept ? (value > MAX_VAL) : ovf_pend_q;
      overflow_d = conv_done ? ovf_pend_q : overflow_q;
      disp_d     = disp_q;
`ifdef LEADING_ZERO_BLANK_EN
      lead       = 1'b1;
`endif
      if (conv_done) begin
         if (ovf_pend_q) begin
            disp_d = {DIGITS{BLANK_CODE}};
         end else begin
            for (int i = 0; i < DIGITS; i++) disp_d[i] = bcd[i*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            for (int i = DIGITS - 1; i > 0; i--) begin
               if (bcd[i*4 +: 4] != 4'd0) lead = 1'b0;
               if (lead) disp_d[i] = BLANK_CODE;
            end
`endif
         end
      end
   end

   // Outputs are registered from next-state index/display so they always agree.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_q == CNW'(REFRESH_DIV - 1)) begin
         cnt_d = '0;
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      for (int i = 0; i < DIGITS; i++) anodes_d[i] = (idx_d != IW'(i));
      digit_d = disp_d[idx_d];
   end

   assign overflow   = overflow_q;
   assign anodes     = anodes_q;
   assign digit_data = digit_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench for bcd_display_driver with a cycle-level arithmetic reference model.
module tb_bcd_display_driver;

   localparam int D  = 4;
   localparam int W  = 14;
   localparam int RD = 4;
   localparam int MAXV = 9999;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load = 1'b0;
   logic [W-1:0]  value = '0;
   logic          busy;
   logic          overflow;
   logic [3:0]    digit_data;
   logic [D-1:0]  anodes;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model state
   int cyc = 0;
   int rem = 0;
   int p_val = 0;
   int m_val = 0;
   bit m_valid = 0;
   bit m_ovf = 0;

   bcd_display_driver #(.DIGITS(D), .WIDTH(W), .REFRESH_DIV(RD)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .value      (value),
      .busy       (busy),
      .overflow   (overflow),
      .digit_data (digit_data),
      .anodes     (anodes)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) begin
         cyc = 0; rem = 0; m_valid = 0; m_ovf = 0;
      end else begin
         cyc++;
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               m_valid = 1; m_val = p_val; m_ovf = (p_val > MAXV);
            end
         end else if (load) begin
            rem = W; p_val = int'(value);
         end
      end
   end

   function automatic int pow10(int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [3:0] exp_digit();
      int k = (cyc / RD) % D;
      if (!m_valid || m_val > MAXV) return 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && m_val < pow10(k)) return 4'hF;
`endif
      return 4'((m_val / pow10(k)) % 10);
   endfunction

   function automatic logic [D-1:0] exp_anodes();
      logic [D-1:0] a = '1;
      a[(cyc / RD) % D] = 1'b0;
      return a;
   endfunction

   function automatic logic [D+5:0] exp_vec();
      return {rem > 0, m_ovf, exp_anodes(), exp_digit()};
   endfunction

   task automatic test_reset();
      logic [D+5:0] got;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      got = {busy, overflow, anodes, digit_data};
      tests_run++;
      if (got !== {1'b0, 1'b0, 4'b1110, 4'hF}) begin
         tests_failed++;
         $display("FAIL reset_hold got=%b exp=%b", got, {1'b0, 1'b0, 4'b1110, 4'hF});
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         got = {busy, overflow, anodes, digit_data};
         tests_run++;
         if (got !== exp_vec() || digit_data !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, got, exp_vec());
         end
      end
   endtask

   task automatic test_convert(input int val, input string name);
      logic [D+5:0] got;
      load = 1'b1; value = W'(val);
      @(negedge clk);
      load = 1'b0;
      for (int i = 0; i < W + D * RD + 2; i++) begin
         got = {busy, overflow, anodes, digit_data};
         tests_run++;
         if (got !== exp_vec()) begin
            tests_failed++;
            $display("FAIL %s val=%0d cyc=%0d got=%b exp=%b", name, val, cyc, got, exp_vec());
         end
         @(negedge clk);
      end
   endtask

   task automatic test_overflow();
      test_convert(10000, "overflow_10000");
      test_convert(9999, "max_9999");
      test_convert(16383, "overflow_max_in");
   endtask

   task automatic test_busy_drop();
      logic [D+5:0] got;
      load = 1'b1; value = W'(42);
      @(negedge clk);
      load = 1'b0;
      for (int i = 0; i < W + D * RD + 4; i++) begin
         load = (i == 2);
         value = (i == 2) ? W'(7) : W'(42);
         got = {busy, overflow, anodes, digit_data};
         tests_run++;
         if (got !== exp_vec()) begin
            tests_failed++;
            $display("FAIL busy_drop cyc=%0d got=%b exp=%b", cyc, got, exp_vec());
         end
         @(negedge clk);
      end
      load = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 15; n++) begin
         test_convert(int'($urandom_range(0, 12000)), "random");
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [D+5:0] got;
      for (int n = 0; n < 4; n++) begin
         load = 1'b1; value = W'($urandom_range(0, 9999));
         @(negedge clk);
         load = 1'b0;
         for (int i = 0; i < W; i++) begin
            got = {busy, overflow, anodes, digit_data};
            tests_run++;
            if (got !== exp_vec()) begin
               tests_failed++;
               $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, got, exp_vec());
            end
            @(negedge clk);
         end
      end
      repeat (D * RD) begin
         got = {busy, overflow, anodes, digit_data};
         tests_run++;
         if (got !== exp_vec()) begin
            tests_failed++;
            $display("FAIL back_to_back_tail cyc=%0d got=%b exp=%b", cyc, got, exp_vec());
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      logic [D+5:0] got;
      load = 1'b1; value = W'(5678);
      @(negedge clk);
      load = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         got = {busy, overflow, anodes, digit_data};
         tests_run++;
         if (got !== {1'b0, 1'b0, 4'b1110, 4'hF}) begin
            tests_failed++;
            $display("FAIL reset_mid got=%b exp=%b", got, {1'b0, 1'b0, 4'b1110, 4'hF});
         end
      end
      reset = 1'b0;
      for (int i = 0; i < W + D * RD + 4; i++) begin
         @(negedge clk);
         got = {busy, overflow, anodes, digit_data};
         tests_run++;
         if (got !== exp_vec() || digit_data !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", cyc, got, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_convert(1234, "value_1234");
      test_overflow();
      test_busy_drop();
      test_convert(0, "value_0");
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
